// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD refresh sequencer: FSM state encoding,
// display geometry, DD-RAM line addresses and a character-extraction helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_L1 = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_WR     = 3'd3,
        ST_WAIT_D = 3'd4,
        ST_SET_L2 = 3'd5,
        ST_DONE   = 3'd6
    } lcd_state_e;

    localparam logic [6:0] LCD_LINE1_ADDR     = 7'h00;
    localparam logic [6:0] LCD_LINE2_ADDR     = 7'h40;
    localparam int         LCD_CHARS_PER_LINE = 16;
    localparam int         LCD_NUM_CHARS      = 32;
    localparam int         LCD_FRAME_W        = 8 * LCD_NUM_CHARS;

    // Character 0 sits in the top byte of the frame word, character 31 in the bottom byte.
    function automatic logic [7:0] lcd_char_at(input logic [LCD_FRAME_W-1:0] frame,
                                               input logic [4:0]             idx);
        logic [LCD_FRAME_W-1:0] shifted;
        shifted = frame << {idx, 3'b000};
        return shifted[LCD_FRAME_W-1 -: 8];
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Generic cycle counter: synchronous clear, count enable, and a terminal-count
// flag that is high while the count equals LIMIT-1. The count wraps to zero
// after the terminal value, so with en tied high tc pulses every LIMIT cycles.
module lcd_cycle_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned    CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Count up while enabled, wrapping after the terminal value; clr has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Copies a latched 2x16 character frame to the LCD through the transaction
// layer, one command in flight at a time, with a done-pulse timeout.
// Optional feature macro: LCD_AUTO_REFRESH_EN adds a free-running period
// counter that raises an internal refresh request every REFRESH_PERIOD cycles.
module lcd_refresh_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned REFRESH_PERIOD = 5000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   refresh_req,
    input  logic [LCD_FRAME_W-1:0] frame_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err,
    input  logic                   txn_ready,
    output logic                   do_set_dd_ram_addr,
    output logic [6:0]             dd_ram_addr,
    input  logic                   set_dd_ram_addr_done,
    output logic                   do_write_data,
    output logic [7:0]             data_to_write,
    input  logic                   send_data_done
);

    if (TIMEOUT_CYCLES < 2 || REFRESH_PERIOD < 2) begin : g_bad_params
        $error("lcd_refresh_sequencer: TIMEOUT_CYCLES and REFRESH_PERIOD must be >= 2");
    end

    lcd_state_e             state_q, state_d;
    logic [4:0]             idx_q;
    logic                   pending_q;
    logic [LCD_FRAME_W-1:0] frame_q;
    logic                   accept;
    logic                   idx_inc;
    logic                   in_wait;
    logic                   tmo_tc;
    logic                   auto_req;
    logic                   req_any;
    logic [7:0]             cur_char;

    assign in_wait  = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_D);
    assign req_any  = refresh_req | auto_req;
    assign cur_char = lcd_char_at(frame_q, idx_q);

    // Timeout counter: held at zero outside the wait states, so it restarts on every wait entry.
    lcd_cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (~in_wait),
        .en    (in_wait),
        .tc    (tmo_tc)
    );

`ifdef LCD_AUTO_REFRESH_EN
    // Free-running period counter; runs regardless of busy, its pulse is an ordinary request.
    lcd_cycle_timer #(.LIMIT(REFRESH_PERIOD)) u_period (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (1'b1),
        .tc    (auto_req)
    );
`else
    assign auto_req = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and command outputs; all outputs are decoded from the state so reset clears them at once.
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        idx_inc            = 1'b0;
        busy               = 1'b0;
        frame_done         = 1'b0;
        timeout_err        = 1'b0;
        do_set_dd_ram_addr = 1'b0;
        dd_ram_addr        = 7'h00;
        do_write_data      = 1'b0;
        data_to_write      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if ((req_any | pending_q) & txn_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SET_L1;
                end
            end
            ST_SET_L1: begin
                busy               = 1'b1;
                do_set_dd_ram_addr = 1'b1;
                dd_ram_addr        = LCD_LINE1_ADDR;
                state_d            = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                busy        = 1'b1;
                dd_ram_addr = (idx_q >= 5'(LCD_CHARS_PER_LINE)) ? LCD_LINE2_ADDR : LCD_LINE1_ADDR;
                if (set_dd_ram_addr_done) begin
                    state_d = ST_WR;
                end else if (tmo_tc) begin
                    busy        = 1'b0;
                    timeout_err = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WR: begin
                busy          = 1'b1;
                do_write_data = 1'b1;
                data_to_write = cur_char;
                state_d       = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                busy          = 1'b1;
                data_to_write = cur_char;
                if (send_data_done) begin
                    if (idx_q == 5'(LCD_NUM_CHARS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = (idx_q == 5'(LCD_CHARS_PER_LINE - 1)) ? ST_SET_L2 : ST_WR;
                    end
                end else if (tmo_tc) begin
                    busy        = 1'b0;
                    timeout_err = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_SET_L2: begin
                busy               = 1'b1;
                do_set_dd_ram_addr = 1'b1;
                dd_ram_addr        = LCD_LINE2_ADDR;
                state_d            = ST_WAIT_A;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                // A request queued during the refresh starts straight away, so its
                // first command lands the cycle after frame_done.
                if (pending_q & txn_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SET_L1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Character index and single-deep pending request; requests not accepted immediately are merged into pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 5'd1;
            end
            if (accept) begin
                pending_q <= 1'b0;
            end else if (req_any) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Frame snapshot taken in the accept cycle; outputs are gated by state, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= frame_data;
        end
    end

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Self-checking bench for lcd_refresh_sequencer: a randomised transaction-layer
// responder, a command monitor and a frame-level reference model.
// Define LCD_AUTO_REFRESH_EN to run the auto-refresh scenario instead.
module tb_lcd_refresh_sequencer;

    localparam int TMO    = 16;
    localparam int PERIOD = 2000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         refresh_req = 1'b0;
    logic [255:0] frame_data = '0;
    logic         txn_ready = 1'b0;
    logic         set_dd_ram_addr_done = 1'b0;
    logic         send_data_done = 1'b0;
    logic         busy, frame_done, timeout_err;
    logic         do_set_dd_ram_addr, do_write_data;
    logic [6:0]   dd_ram_addr;
    logic [7:0]   data_to_write;

    lcd_refresh_sequencer #(.TIMEOUT_CYCLES(TMO), .REFRESH_PERIOD(PERIOD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .refresh_req          (refresh_req),
        .frame_data           (frame_data),
        .busy                 (busy),
        .frame_done           (frame_done),
        .timeout_err          (timeout_err),
        .txn_ready            (txn_ready),
        .do_set_dd_ram_addr   (do_set_dd_ram_addr),
        .dd_ram_addr          (dd_ram_addr),
        .set_dd_ram_addr_done (set_dd_ram_addr_done),
        .do_write_data        (do_write_data),
        .data_to_write        (data_to_write),
        .send_data_done       (send_data_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int cmd_kind[$], cmd_val[$], cmd_t[$], done_t[$], fdone_t[$], tmo_t[$];
    int busy_cycles = 0, tmo_busy = 0, overlap = 0;
    int resp_lat = 3;
    bit resp_noise = 1'b0;
    int withhold_idx = -1;
    int resp_count = 0;
    int exp_kind[34], exp_val[34];

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint out_vec();
        logic [19:0] v;
        v = {busy, frame_done, timeout_err, do_set_dd_ram_addr, do_write_data, dd_ram_addr, data_to_write};
        return $isunknown(v) ? -1 : longint'(v);
    endfunction

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[32*k +: 32] = $urandom;
        return f;
    endfunction

    // Command monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (do_set_dd_ram_addr) begin
                cmd_kind.push_back(0); cmd_val.push_back(int'(dd_ram_addr)); cmd_t.push_back(cyc);
            end
            if (do_write_data) begin
                cmd_kind.push_back(1); cmd_val.push_back(int'(data_to_write)); cmd_t.push_back(cyc);
            end
            if (do_set_dd_ram_addr && do_write_data) overlap++;
            if (frame_done) fdone_t.push_back(cyc);
            if (timeout_err) begin
                tmo_t.push_back(cyc);
                if (busy) tmo_busy++;
            end
            if (busy) busy_cycles++;
        end
    end

    // Transaction-layer responder: answers each command after lat cycles, optionally
    // injecting a wrong-type done first, or withholding the answer to one command.
    initial begin
        int         is_wr, lat;
        logic [7:0] held;
        bit         drop;
        forever begin
            @(posedge clk); #1;
            while (!reset && (do_set_dd_ram_addr || do_write_data)) begin
                is_wr = int'(do_write_data);
                held  = is_wr != 0 ? data_to_write : {1'b0, dd_ram_addr};
                lat   = (resp_lat == 0) ? int'($urandom_range(4, 1)) : resp_lat;
                drop  = (resp_count == withhold_idx);
                resp_count++;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    set_dd_ram_addr_done = 1'b0;
                    send_data_done       = 1'b0;
                    if (resp_noise && i == 0 && lat > 1) begin
                        if (is_wr != 0) set_dd_ram_addr_done = 1'b1;
                        else            send_data_done       = 1'b1;
                    end
                end
                set_dd_ram_addr_done = 1'b0;
                send_data_done       = 1'b0;
                if (drop) begin
                    done_t.push_back(-1);
                end else if (!reset) begin
                    check_val("held_value", is_wr != 0 ? longint'(data_to_write) : longint'(dd_ram_addr), longint'(held));
                    if (is_wr != 0) send_data_done = 1'b1;
                    else            set_dd_ram_addr_done = 1'b1;
                    done_t.push_back(cyc);
                end
                @(posedge clk); #1;
                set_dd_ram_addr_done = 1'b0;
                send_data_done       = 1'b0;
            end
        end
    end

    // Reference model: address 00, chars 0..15, address 40, chars 16..31.
    task automatic build_expected(input logic [255:0] f);
        int j = 0;
        for (int line = 0; line < 2; line++) begin
            exp_kind[j] = 0;
            exp_val[j]  = (line == 0) ? 'h00 : 'h40;
            j++;
            for (int c = 0; c < 16; c++) begin
                exp_kind[j] = 1;
                exp_val[j]  = int'(f[255 - 8*(16*line + c) -: 8]);
                j++;
            end
        end
    endtask

    task automatic verify_frame(input logic [255:0] f, input int base, input int first_t,
                                input int fi, input string tag);
        int bad_seq = 0;
        int bad_t = 0;
        int avail;
        build_expected(f);
        avail = cmd_kind.size() - base;
        check_val({tag, ".ncmds"}, (avail > 34) ? 34 : avail, 34);
        if (cmd_kind.size() >= base + 34 && done_t.size() >= base + 34 && fdone_t.size() > fi) begin
            for (int j = 0; j < 34; j++)
                if (cmd_kind[base+j] != exp_kind[j] || cmd_val[base+j] != exp_val[j]) bad_seq++;
            for (int j = 0; j < 33; j++)
                if (cmd_t[base+j+1] != done_t[base+j] + 1) bad_t++;
            check_val({tag, ".sequence_errs"}, bad_seq, 0);
            check_val({tag, ".first_cmd_cycle"}, cmd_t[base], first_t);
            check_val({tag, ".done_to_cmd_errs"}, bad_t, 0);
            check_val({tag, ".frame_done_cycle"}, fdone_t[fi], done_t[base+33] + 1);
        end
    endtask

    task automatic wait_counts(input int nf, input int nt, input int nc, input int budget, input string tag);
        int k = 0;
        while ((fdone_t.size() < nf || tmo_t.size() < nt || cmd_kind.size() < nc) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, ".reached"},
                  (fdone_t.size() >= nf && tmo_t.size() >= nt && cmd_kind.size() >= nc) ? 1 : 0, 1);
    endtask

    task automatic pulse_req(output int t);
        t = cyc;
        refresh_req = 1'b1;
        @(posedge clk); #1;
        refresh_req = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_q();
        cmd_kind.delete(); cmd_val.delete(); cmd_t.delete();
        done_t.delete(); fdone_t.delete(); tmo_t.delete();
        busy_cycles = 0; tmo_busy = 0; resp_count = 0;
    endtask

    initial begin
        logic [255:0] f1, f2;
        int t, t2, r, n0, bad;
        settle(3);
        check_val("reset.outputs", out_vec(), 0);
`ifdef LCD_AUTO_REFRESH_EN
        f1 = rand_frame();
        frame_data = f1;
        resp_lat = 1;
        txn_ready = 1'b1;
        r = cyc;
        reset = 1'b0;
        wait_counts(4, 0, 0, 4*PERIOD + 300, "auto");
        verify_frame(f1, 0, r + PERIOD, 0, "auto.first");
        for (int k = 1; k < 4; k++)
            if (fdone_t.size() > k) check_val("auto.period", fdone_t[k] - fdone_t[k-1], PERIOD);
        check_val("auto.ncmds", cmd_kind.size(), 4*34);
`else
        reset = 1'b0;
        txn_ready = 1'b1;
        settle(5);
        check_val("idle.ncmds", cmd_kind.size(), 0);
        check_val("idle.busy", busy, 0);

        // Fixed text frame, responder latency 3
        f1 = {"HELLO WORLD.....", "0123456789ABCDEF"};
        frame_data = f1;
        resp_lat = 3;
        pulse_req(t);
        frame_data = rand_frame();
        wait_counts(1, 0, 34, 400, "t1");
        verify_frame(f1, 0, t + 1, 0, "t1");
        check_val("t1.first_char", (cmd_val.size() > 1) ? cmd_val[1] : -1, 72);
        check_val("t1.busy_cycles", busy_cycles, (fdone_t.size() > 0) ? fdone_t[0] - t - 1 : -1);
        settle(10);
        check_val("t1.nframes", fdone_t.size(), 1);
        clear_q();

        // Zero-latency responder
        f1 = rand_frame();
        frame_data = f1;
        resp_lat = 1;
        pulse_req(t);
        frame_data = rand_frame();
        wait_counts(1, 0, 34, 200, "t2");
        verify_frame(f1, 0, t + 1, 0, "t2");
        check_val("t2.frame_cycle", (fdone_t.size() > 0) ? fdone_t[0] : -1, t + 69);
        settle(10);
        check_val("t2.nframes", fdone_t.size(), 1);
        clear_q();

        // Two requests during busy merge into one extra refresh
        f1 = rand_frame();
        f2 = rand_frame();
        frame_data = f1;
        resp_lat = 0;
        resp_noise = 1'b1;
        pulse_req(t);
        frame_data = f2;
        wait_counts(0, 0, 5, 100, "t3a");
        pulse_req(t2);
        wait_counts(0, 0, 12, 200, "t3b");
        pulse_req(t2);
        wait_counts(2, 0, 68, 1000, "t3");
        settle(40);
        check_val("t3.nframes", fdone_t.size(), 2);
        check_val("t3.ncmds_total", cmd_kind.size(), 68);
        verify_frame(f1, 0, t + 1, 0, "t3.first");
        verify_frame(f2, 34, (fdone_t.size() > 0) ? fdone_t[0] + 1 : -1, 1, "t3.extra");
        resp_noise = 1'b0;
        clear_q();

        // Timeout while waiting for char 6; a request made during the wait survives the abort
        f1 = rand_frame();
        frame_data = f1;
        resp_lat = 2;
        withhold_idx = 7;
        pulse_req(t);
        wait_counts(0, 0, 8, 200, "t4a");
        pulse_req(t2);
        wait_counts(0, 1, 0, 100, "t4b");
        check_val("t4.ncmds_at_abort", cmd_kind.size(), 8);
        check_val("t4.tmo_cycle", (tmo_t.size() > 0 && cmd_t.size() > 7) ? tmo_t[0] - cmd_t[7] : -1, TMO);
        check_val("t4.busy_at_abort", tmo_busy, 0);
        check_val("t4.no_frame_done", fdone_t.size(), 0);
        build_expected(f1);
        bad = 0;
        for (int j = 0; j < 8; j++)
            if (cmd_kind.size() > j && (cmd_kind[j] != exp_kind[j] || cmd_val[j] != exp_val[j])) bad++;
        check_val("t4.prefix_errs", bad, 0);
        withhold_idx = -1;
        wait_counts(1, 1, 42, 400, "t4c");
        verify_frame(f1, 8, (tmo_t.size() > 0) ? tmo_t[0] + 2 : -1, 0, "t4.retry");
        settle(10);
        check_val("t4.ntimeouts", tmo_t.size(), 1);
        clear_q();

        // Reset during char 20 clears outputs at once and drops the pending request
        f1 = rand_frame();
        frame_data = f1;
        resp_lat = 0;
        pulse_req(t);
        wait_counts(0, 0, 10, 200, "t5a");
        pulse_req(t2);
        wait_counts(0, 0, 23, 300, "t5b");
        check_val("t5.char20", (cmd_val.size() > 22) ? cmd_val[22] : -1, int'(f1[255 - 8*20 -: 8]));
        n0 = cmd_kind.size();
        #2 reset = 1'b1;
        #1 check_val("t5.async_clear", out_vec(), 0);
        settle(8);
        reset = 1'b0;
        settle(30);
        check_val("t5.no_restart", cmd_kind.size(), n0);
        check_val("t5.no_frame_done", fdone_t.size(), 0);
        check_val("t5.idle_busy", busy, 0);
        clear_q();
        f2 = rand_frame();
        frame_data = f2;
        pulse_req(t);
        wait_counts(1, 0, 34, 400, "t5c");
        check_val("t5.first_addr", (cmd_val.size() > 0) ? cmd_val[0] : -1, 0);
        verify_frame(f2, 0, t + 1, 0, "t5.restart");
        settle(10);
        clear_q();

        // Request while the transaction layer is not ready waits for txn_ready
        txn_ready = 1'b0;
        f1 = rand_frame();
        frame_data = f1;
        pulse_req(t);
        settle(10);
        check_val("t6.held_off", cmd_kind.size(), 0);
        r = cyc;
        txn_ready = 1'b1;
        wait_counts(1, 0, 34, 400, "t6");
        verify_frame(f1, 0, r + 1, 0, "t6");
        settle(5);
        clear_q();

        // Random frames with random latency, with and without wrong-type done pulses
        for (int k = 0; k < 4; k++) begin
            f1 = rand_frame();
            frame_data = f1;
            resp_lat = 0;
            resp_noise = k[0];
            pulse_req(t);
            frame_data = rand_frame();
            wait_counts(1, 0, 34, 500, "rnd");
            verify_frame(f1, 0, t + 1, 0, "rnd");
            settle(5);
            clear_q();
        end
`endif
        check_val("one_in_flight", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
